inv_transform: RTL and testbench

- Inverse of the screen-to-template coordinate transform: maps a template-space point (cv_x, cv_y) back to screen pixel coordinates (x, y).
- Scales by screen size over template size: x = cv_x*SCREEN_W/t_width, y = cv_y*SCREEN_H/t_height.
- Multi-cycle block: one multiply stage, then two parallel iterative restoring dividers. Used to place overlay/marker pixels back on the display after template-space processing.

---
 rtl/inv_transform_if.sv | 30 +++
 rtl/inv_transform.sv | 140 ++++++++++++++
 tb/tb_inv_transform.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/inv_transform_if.sv
// Request/result bundle for inv_transform: operands and start in, status and screen coordinates out.
// Handshake: start is a one-cycle request honoured only while busy=0; done pulses for exactly
// one cycle and x/y/sat_x/sat_y are valid from that cycle until the next done.
interface inv_transform_if #(
  parameter int CW = 13,
  parameter int XW = 11,
  parameter int YW = 10
);
  logic          start;
  logic [CW-1:0] cv_x;
  logic [CW-1:0] cv_y;
  logic [XW-1:0] t_width;
  logic [XW-1:0] t_height;
  logic          busy;
  logic          done;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          sat_x;
  logic          sat_y;

  modport master (
    output start, cv_x, cv_y, t_width, t_height,
    input  busy, done, x, y, sat_x, sat_y
  );

  modport slave (
    input  start, cv_x, cv_y, t_width, t_height,
    output busy, done, x, y, sat_x, sat_y
  );
endinterface

// File: rtl/inv_transform.sv
// Maps a template-space point back to screen pixels: x = cv_x*SCREEN_W/t_width, y = cv_y*SCREEN_H/t_height,
// using one multiply cycle and two lockstep restoring dividers (one quotient bit per cycle).
module inv_transform #(
  parameter int SCREEN_W = 1024,
  parameter int SCREEN_H = 768,
  parameter int XW       = 11,
  parameter int YW       = 10,
  parameter int CW       = 13,
  parameter int PW       = CW + XW
) (
  input  logic         clk,
  input  logic         reset,
  inv_transform_if.slave bus,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

  localparam int CNTW = $clog2(PW);
  localparam logic [PW-1:0] SW_K = PW'(SCREEN_W);
  localparam logic [PW-1:0] SH_K = PW'(SCREEN_H);
  localparam logic [PW-1:0] XMAX = PW'(SCREEN_W - 1);
  localparam logic [PW-1:0] YMAX = PW'(SCREEN_H - 1);

  state_t state, state_nxt;

  logic [CNTW-1:0] cnt;
  logic [CW-1:0]   cx_r, cy_r;
  logic [XW-1:0]   tw_r, th_r;
  logic [PW-1:0]   dx, dy, qx, qy;
  logic [XW:0]     rx, ry;

  logic [PW-1:0] px, py;
  logic [XW:0]   rx_sh, ry_sh, dvx, dvy, rx_nxt, ry_nxt;
  logic          x_ge, y_ge;
  logic [PW-1:0] qx_nxt, qy_nxt;
  logic          x_sat, y_sat;
  logic [XW-1:0] x_val;
  logic [YW-1:0] y_val;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = MUL;
      MUL:     state_nxt = DIV;
      DIV:     if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == DONE);
  assign dbg_state = state;

  assign px = PW'(cx_r) * SW_K;
  assign py = PW'(cy_r) * SH_K;

  // The remainder's top bit can only be set with a zero divisor; forcing a subtract
  // then keeps the all-ones quotient that the saturation logic relies on.
  always_comb begin
    dvx    = {1'b0, tw_r};
    dvy    = {1'b0, th_r};
    rx_sh  = {rx[XW-1:0], dx[PW-1]};
    ry_sh  = {ry[XW-1:0], dy[PW-1]};
    x_ge   = rx[XW] | (rx_sh >= dvx);
    y_ge   = ry[XW] | (ry_sh >= dvy);
    rx_nxt = x_ge ? (rx_sh - dvx) : rx_sh;
    ry_nxt = y_ge ? (ry_sh - dvy) : ry_sh;
    qx_nxt = {qx[PW-2:0], x_ge};
    qy_nxt = {qy[PW-2:0], y_ge};
    x_sat  = (qx_nxt > XMAX) | (tw_r == '0);
    y_sat  = (qy_nxt > YMAX) | (th_r == '0);
    x_val  = x_sat ? XMAX[XW-1:0] : qx_nxt[XW-1:0];
    y_val  = y_sat ? YMAX[YW-1:0] : qy_nxt[YW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      cx_r      <= '0;
      cy_r      <= '0;
      tw_r      <= '0;
      th_r      <= '0;
      dx        <= '0;
      dy        <= '0;
      qx        <= '0;
      qy        <= '0;
      rx        <= '0;
      ry        <= '0;
      bus.x     <= '0;
      bus.y     <= '0;
      bus.sat_x <= 1'b0;
      bus.sat_y <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            cx_r <= bus.cv_x;
            cy_r <= bus.cv_y;
            tw_r <= bus.t_width;
            th_r <= bus.t_height;
          end
        end
        MUL: begin
          dx  <= px;
          dy  <= py;
          qx  <= '0;
          qy  <= '0;
          rx  <= '0;
          ry  <= '0;
          cnt <= CNTW'(PW - 1);
        end
        DIV: begin
          dx  <= dx << 1;
          dy  <= dy << 1;
          rx  <= rx_nxt;
          ry  <= ry_nxt;
          qx  <= qx_nxt;
          qy  <= qy_nxt;
          cnt <= cnt - CNTW'(1);
          // Results are captured from the final quotient bit so they are valid during DONE.
          if (cnt == '0) begin
            bus.x     <= x_val;
            bus.y     <= y_val;
            bus.sat_x <= x_sat;
            bus.sat_y <= y_sat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_transform.sv
// Directed bench for inv_transform: hand-computed vectors, busy/done timing, ignored starts and reset abort.
module tb_inv_transform;
  localparam int CW = 13;
  localparam int XW = 11;
  localparam int YW = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  int total = 0;
  int bad   = 0;
  int lat, bcnt, dcnt;

  always #5 clk = ~clk;

  inv_transform_if #(.CW(CW), .XW(XW), .YW(YW)) bus ();

  inv_transform dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int cx, input int cy, input int tw, input int th);
    bus.cv_x     = CW'(cx);
    bus.cv_y     = CW'(cy);
    bus.t_width  = XW'(tw);
    bus.t_height = XW'(th);
  endtask

  // Called at a negedge while idle. Cycle n is the n-th cycle after the edge that samples start.
  // inj_a/inj_b re-assert start with other operands in those cycles; they must be ignored.
  // Returns one cycle after done (lat = done cycle, -1 on timeout).
  task automatic run_op(input int cx, input int cy, input int tw, input int th,
                        input int inj_a, input int inj_b, output int lat_o, output int bcnt_o);
    int n;
    set_ops(cx, cy, tw, th);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bcnt_o = 0;
    n = 1;
    while (!bus.done && n < 40) begin
      if (bus.busy) bcnt_o++;
      if (n == inj_a) begin
        bus.start = 1'b1;
        set_ops(10, 10, 5, 5);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    if (bus.busy) bcnt_o++;
    lat_o = bus.done ? n : -1;
    if (n == inj_b) begin
      bus.start = 1'b1;
      set_ops(10, 10, 5, 5);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic check_res(input string pfx, input int ex, input int ey, input int sx, input int sy);
    chk({pfx, ".lat"},   lat, 26);
    chk({pfx, ".x"},     bus.x, ex);
    chk({pfx, ".y"},     bus.y, ey);
    chk({pfx, ".sat_x"}, bus.sat_x, sx);
    chk({pfx, ".sat_y"}, bus.sat_y, sy);
    chk({pfx, ".done_1cyc"}, bus.done, 0);
    chk({pfx, ".idle"},  bus.busy, 0);
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    set_ops(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst.busy",  bus.busy, 0);
    chk("rst.done",  bus.done, 0);
    chk("rst.x",     bus.x, 0);
    chk("rst.y",     bus.y, 0);
    chk("rst.sat_x", bus.sat_x, 0);
    chk("rst.sat_y", bus.sat_y, 0);
    chk("rst.state", dbg_state, 0);

    // 60*1024/120 = 512, 30*768/120 = 192
    run_op(60, 30, 120, 120, 0, 0, lat, bcnt);
    chk("nom.busy_cycles", bcnt, 26);
    check_res("nom", 512, 192, 0, 0);

    // 200*1024/120 = 1706 -> 1023, 200*768/120 = 1280 -> 767
    run_op(200, 200, 120, 120, 0, 0, lat, bcnt);
    check_res("sat", 1023, 767, 1, 1);

    // zero width saturates x; 768/7 = 109.7 truncates to 109
    run_op(5, 1, 0, 7, 0, 0, lat, bcnt);
    check_res("div0", 1023, 109, 1, 0);

    // 100*1024/200 = 512, 50*768/100 = 384; starts at cycles 5 and 26 must be ignored
    run_op(100, 50, 200, 100, 5, 26, lat, bcnt);
    check_res("busy_start", 512, 384, 0, 0);

    // accepted in cycle 27: 33*1024/100 = 337, 77*768/300 = 197
    run_op(33, 77, 100, 300, 0, 0, lat, bcnt);
    check_res("after_busy", 337, 197, 0, 0);

    // reset in cycle 10 of a DIV aborts with cleared outputs and no done pulse
    set_ops(60, 30, 120, 120);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid.busy",  bus.busy, 0);
    chk("rstmid.x",     bus.x, 0);
    chk("rstmid.y",     bus.y, 0);
    chk("rstmid.state", dbg_state, 0);
    dcnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.done) dcnt++;
      @(negedge clk);
    end
    chk("rstmid.no_done", dcnt, 0);

    // 3*1024/7 = 438, 5*768/9 = 426
    run_op(3, 5, 7, 9, 0, 0, lat, bcnt);
    check_res("post_rst", 438, 426, 0, 0);

    // x = 0; 768/1 = 768 just over the y limit
    run_op(0, 1, 1, 1, 0, 0, lat, bcnt);
    check_res("edge0", 0, 767, 0, 1);

    // exact ratios: 1024/1024 = 1, 767*768/768 = 767 on the limit
    run_op(1, 767, 1024, 768, 0, 0, lat, bcnt);
    check_res("edge1", 1, 767, 0, 0);

    // 1023*1024/1024 = 1023 on the limit, 8191*768/2047 = 3073 -> 767
    run_op(1023, 8191, 1024, 2047, 0, 0, lat, bcnt);
    check_res("edge2", 1023, 767, 0, 1);

    // 8191*1024/2047 = 4097 -> 1023
    run_op(8191, 8191, 2047, 2047, 0, 0, lat, bcnt);
    check_res("edge3", 1023, 767, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
